memory_column_ctrl: RTL and testbench

Round-robin access controller that shares one `memory_column` (DEPTH × ELEM_WIDTH register array) between NUM_REQ requesters. Each requester issues single-beat reads or writes over a valid/ready handshake. Read data is returned one cycle later through a registered response. A fill sequencer can sweep a constant value into every location, one per cycle, while requests are stalled. The block sits directly in front of the column and owns its `en_i`/`addr`/`in` inputs.

---
 rtl/memory_column_ctrl_pkg.sv | 17 +
 rtl/memory_column_ctrl_if.sv | 28 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/memory_column_ctrl.sv | 122 ++++++++++++
 tb/tb_memory_column_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/memory_column_ctrl_pkg.sv
// memory_column_ctrl_pkg
//   Shared types and helpers for the memory column access controller.
//   - ctrl_state_e    : controller FSM states
//   - ctrl_addr_width : address width for a given column depth
package memory_column_ctrl_pkg;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_FILL = 1'b1
  } ctrl_state_e;

  // Clamped to 1 so a degenerate single-entry column still has an address bit.
  function automatic int ctrl_addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/memory_column_ctrl_if.sv
// memory_column_ctrl_if
//   Requester-side bus of the memory column controller: per-requester
//   single-beat valid/ready requests plus the shared registered read response.
//   master : requester side (drives req_*, receives ready and responses)
//   slave  : controller side
interface memory_column_ctrl_if #(
  parameter int NUM_REQ    = 4,
  parameter int ELEM_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][ELEM_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [ELEM_WIDTH-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. Grants the first asserted request searching upward
//   from an internal pointer with wrap-around; the pointer moves past the
//   granted requester only when the grant is consumed.
//   clk_i, arst_ni : clock, async active-low reset
//   req_i          : request vector
//   advance_i      : grant consumed this cycle, rotate priority
//   gnt_o          : one-hot grant (zero when no request)
//   gnt_idx_o      : index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  int               w_idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req_i[IDX_W'(w_idx)]) begin
        w_found                = 1'b1;
        gnt_o[IDX_W'(w_idx)]   = 1'b1;
        gnt_idx_o              = IDX_W'(w_idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)       r_ptr <= '0;
    else if (advance_i) r_ptr <= (gnt_idx_o == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_o + 1'b1;
  end

endmodule

// File: rtl/memory_column_ctrl.sv
// memory_column_ctrl
//   Shares one memory column between NUM_REQ requesters with round-robin
//   arbitration, one access per cycle, read latency 1. A fill sweep writes a
//   captured constant to every location (one per cycle) while requests stall.
//   clk_i, arst_ni   : clock, async active-low reset (shared with the column)
//   bus              : requester bus (valid/ready/we/addr/wdata, rsp_valid/rdata)
//   fill_i           : fill start, level-sampled in idle
//   fill_value_i     : fill value, captured on fill acceptance
//   busy_o           : fill in progress
//   fill_done_o      : one-cycle pulse after the last fill write
//   mem_en_o/addr_o/wdata_o : column write enable, address, write data
//   mem_rdata_i      : combinational column read data
module memory_column_ctrl
  import memory_column_ctrl_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  ELEM_WIDTH = 8,
  parameter int  DEPTH      = 1024,
  localparam int ADDR_WIDTH = ctrl_addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  memory_column_ctrl_if.slave   bus,
  input  logic                  fill_i,
  input  logic [ELEM_WIDTH-1:0] fill_value_i,
  output logic                  busy_o,
  output logic                  fill_done_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [ELEM_WIDTH-1:0] mem_wdata_o,
  input  logic [ELEM_WIDTH-1:0] mem_rdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  ctrl_state_e           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [ELEM_WIDTH-1:0] r_fill_val, w_fill_val_nxt;
  logic                  r_fill_done, w_fill_done_nxt;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [ELEM_WIDTH-1:0] r_rsp_rdata;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_grant;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_mem_en;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .req_i     (bus.req_valid),
    .advance_i (w_grant),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_fill_val_nxt  = r_fill_val;
    w_fill_done_nxt = 1'b0;
    w_grant         = 1'b0;
    w_ready         = '0;
    w_mem_en        = 1'b0;
    mem_addr_o      = bus.req_addr[w_gnt_idx];
    mem_wdata_o     = bus.req_wdata[w_gnt_idx];
    unique case (r_state)
      CTRL_IDLE: begin
        if (fill_i) begin
          // Fill wins over any pending request this cycle.
          w_state_nxt    = CTRL_FILL;
          w_cnt_nxt      = '0;
          w_fill_val_nxt = fill_value_i;
        end else begin
          w_grant  = |w_gnt;
          w_ready  = w_gnt;
          w_mem_en = w_grant & bus.req_we[w_gnt_idx];
        end
      end
      CTRL_FILL: begin
        w_mem_en    = 1'b1;
        mem_addr_o  = r_cnt;
        mem_wdata_o = r_fill_val;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == ADDR_WIDTH'(DEPTH-1)) begin
          w_state_nxt     = CTRL_IDLE;
          w_fill_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state     <= CTRL_IDLE;
      r_cnt       <= '0;
      r_fill_val  <= '0;
      r_fill_done <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fill_val  <= w_fill_val_nxt;
      r_fill_done <= w_fill_done_nxt;
      // Grant is one-hot, so masking by ~we leaves only an accepted read.
      r_rsp_valid <= w_ready & ~bus.req_we;
      if (w_grant && !bus.req_we[w_gnt_idx]) r_rsp_rdata <= mem_rdata_i;
    end
  end

  // Combinational handshake outputs are forced low while reset is held.
  assign bus.req_ready = w_ready & {NUM_REQ{arst_ni}};
  assign mem_en_o      = w_mem_en & arst_ni;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign busy_o        = (r_state == CTRL_FILL);
  assign fill_done_o   = r_fill_done;

endmodule

// File: tb/tb_memory_column_ctrl.sv
// tb_memory_column_ctrl
//   Directed bench for memory_column_ctrl with a behavioural column model.
//   Read responses are queued at issue time and checked by a separate monitor.
module tb_memory_column_ctrl;
  localparam int NR = 4, EW = 8, DEPTH = 1024, AW = 10;
  localparam logic [EW-1:0] RESET_VALUE = 8'h00;

  logic clk = 1'b0, arst_n = 1'b0;
  always #5 clk = ~clk;

  memory_column_ctrl_if #(.NUM_REQ(NR), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW)) bus();

  logic          fill, busy, fill_done, mem_en;
  logic [EW-1:0] fill_value, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  memory_column_ctrl #(.NUM_REQ(NR), .ELEM_WIDTH(EW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .arst_ni(arst_n), .bus(bus),
    .fill_i(fill), .fill_value_i(fill_value),
    .busy_o(busy), .fill_done_o(fill_done),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Column model: shares the reset, combinational read.
  logic [EW-1:0] col [DEPTH];
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) for (int i = 0; i < DEPTH; i++) col[i] <= RESET_VALUE;
    else if (mem_en) col[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = col[mem_addr];

  typedef struct { logic [NR-1:0] v; logic [EW-1:0] d; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Check the grant this cycle; queue the read response it should produce.
  task automatic issue(input string name, input logic [NR-1:0] exp_rdy,
                       input logic push, input logic [EW-1:0] d);
    @(negedge clk);
    chk(name, 32'(bus.req_ready), 32'(exp_rdy));
    if (push) sbq.push_back('{exp_rdy, d});
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a, input logic [EW-1:0] d);
    bus.req_valid    = '0;
    bus.req_valid[r] = 1'b1;
    bus.req_we[r]    = we;
    bus.req_addr[r]  = a;
    bus.req_wdata[r] = d;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (arst_n && bus.rsp_valid !== '0) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got valid %b data %0h expected no response", bus.rsp_valid, bus.rsp_rdata);
      end else begin
        e = sbq.pop_front();
        if (bus.rsp_valid !== e.v || bus.rsp_rdata !== e.d) begin
          n_fail++;
          $display("FAIL rsp: got valid %b data %0h expected valid %b data %0h",
                   bus.rsp_valid, bus.rsp_rdata, e.v, e.d);
        end
      end
    end
  end

  int bad, pulses, busy_cyc;

  initial begin
    bus.req_valid = '1; bus.req_we = '0; bus.req_wdata = '0;
    for (int i = 0; i < NR; i++) bus.req_addr[i] = AW'(i);
    fill = 1'b0; fill_value = '0;

    // Reset with every requester valid.
    #3;
    chk("rst_ready",     32'(bus.req_ready), 0);
    chk("rst_mem_en",    32'(mem_en), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    issue("first_grant", 4'b0001, 1'b1, RESET_VALUE);

    // Write then read-back on the very next cycle.
    set_req(0, 1'b1, 10'd5, 8'hA5); issue("wr_grant", 4'b0001, 1'b0, '0);
    set_req(0, 1'b0, 10'd5, 8'h00); issue("rd_grant", 4'b0001, 1'b1, 8'hA5);

    // Distinct data per requester; leaves the pointer at 0.
    set_req(0, 1'b1, 10'd0, 8'h44); issue("wr0", 4'b0001, 1'b0, '0);
    set_req(1, 1'b1, 10'd1, 8'h11); issue("wr1", 4'b0010, 1'b0, '0);
    set_req(2, 1'b1, 10'd2, 8'h22); issue("wr2", 4'b0100, 1'b0, '0);
    set_req(3, 1'b1, 10'd3, 8'h33); issue("wr3", 4'b1000, 1'b0, '0);

    // All four read continuously: 0,1,2,3,0,1.
    bus.req_we = '0;
    for (int i = 0; i < NR; i++) bus.req_addr[i] = AW'(i);
    bus.req_valid = 4'b1111;
    issue("rr_all_0", 4'b0001, 1'b1, 8'h44);
    issue("rr_all_1", 4'b0010, 1'b1, 8'h11);
    issue("rr_all_2", 4'b0100, 1'b1, 8'h22);
    issue("rr_all_3", 4'b1000, 1'b1, 8'h33);
    issue("rr_all_4", 4'b0001, 1'b1, 8'h44);
    issue("rr_all_5", 4'b0010, 1'b1, 8'h11);

    // Only 1 and 3 valid; pointer is at 2 so 3 goes first.
    bus.req_valid = 4'b1010;
    issue("rr_13_0", 4'b1000, 1'b1, 8'h33);
    issue("rr_13_1", 4'b0010, 1'b1, 8'h11);
    issue("rr_13_2", 4'b1000, 1'b1, 8'h33);
    issue("rr_13_3", 4'b0010, 1'b1, 8'h11);

    // Fill priority over a pending read of addr 1023 by req1.
    set_req(1, 1'b0, 10'd1023, 8'h00);
    fill = 1'b1; fill_value = 8'h3C;
    @(negedge clk);
    chk("fill_acc_ready", 32'(bus.req_ready), 0);
    chk("fill_acc_busy",  32'(busy), 0);
    cyc();
    fill = 1'b0; fill_value = 8'hFF;
    bad = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || bus.req_ready !== '0 || mem_en !== 1'b1 ||
          mem_addr !== AW'(k-1) || mem_wdata !== 8'h3C || fill_done !== 1'b0) bad++;
      cyc();
    end
    chk("fill_stall_cycles", 32'(bad), 0);
    @(negedge clk);
    chk("fill_done_pulse", 32'(fill_done), 1);
    chk("fill_done_busy",  32'(busy), 0);
    chk("fill_end_grant",  32'(bus.req_ready), 32'(4'b0010));
    sbq.push_back('{4'b0010, 8'h3C});
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    chk("fill_done_clear", 32'(fill_done), 0);
    cyc();

    // Fill re-request mid-sweep must be ignored.
    fill = 1'b1; fill_value = 8'h5A;
    cyc();
    fill = 1'b0;
    pulses = 0; busy_cyc = 0;
    for (int k = 1; k <= DEPTH + 6; k++) begin
      @(negedge clk);
      if (fill_done === 1'b1) pulses++;
      if (busy === 1'b1) busy_cyc++;
      cyc();
      if (k == 300) begin fill = 1'b1; fill_value = 8'hFF; end
      if (k == 310) fill = 1'b0;
    end
    chk("ign_done_pulses", 32'(pulses), 1);
    chk("ign_busy_cycles", 32'(busy_cyc), DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      set_req(2, 1'b0, AW'(a), 8'h00);
      issue("sweep_grant", 4'b0100, 1'b1, 8'h5A);
    end
    bus.req_valid = '0;
    cyc(); cyc();

    // Reset in the middle of a fill.
    fill = 1'b1; fill_value = 8'h77;
    cyc();
    fill = 1'b0;
    repeat (500) cyc();
    chk("midfill_busy_pre", 32'(busy), 1);
    bus.req_valid = 4'b0001;
    arst_n = 1'b0;
    #1;
    chk("midfill_busy",      32'(busy), 0);
    chk("midfill_ready",     32'(bus.req_ready), 0);
    chk("midfill_mem_en",    32'(mem_en), 0);
    chk("midfill_rsp_valid", 32'(bus.rsp_valid), 0);
    cyc();
    arst_n = 1'b1;
    set_req(0, 1'b0, 10'd600, 8'h00); issue("post_rst_600", 4'b0001, 1'b1, RESET_VALUE);
    set_req(0, 1'b0, 10'd10,  8'h00); issue("post_rst_10",  4'b0001, 1'b1, RESET_VALUE);
    bus.req_valid = '0;
    cyc(); cyc();
    chk("sb_drain", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
